mcu_control_sequencer: RTL and testbench
========================================

# mcu_control_sequencer

Multi-cycle fetch/execute controller for the 8-bit MCU datapath. It fetches 16-bit instructions through a valid-qualified handshake and holds them in an instruction register. It decodes each instruction into the per-cycle control word (DA, AA, BA, MB, CS, FS, RW) that drives the register file, the B-bus source mux and the function unit. It also owns the program counter, including conditional and unconditional relative branches.

## Interface
- Parameters: none (datapath 8 bits, PC 8 bits, instruction 16 bits, fixed).
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  leave IDLE and begin fetching at PC
- instr_in  input  16  instruction word for address pc_out
- instr_valid  input  1  instr_in valid; sampled only in FETCH
- zero  input  1  function-unit zero flag of current F result
- pc_out  output  8  fetch address
- fetch_req  output  1  high while in FETCH
- DA / AA / BA  output  3 each  destination / A-source / B-source register address
- MB  output  1  B-bus select: 0 = register B, 1 = constant CS
- CS  output  8  constant driven to the B-bus mux
- FS  output  4  function select
- RW  output  1  register-file write enable
- busy  output  1  high in FETCH or EXEC
- halted  output  1  high in HALT

## Operation
- Instruction fields:
  - op = [15:12], DR = [11:9], SA = [8:6], SB = [5:3], imm6 = [5:0].
  - sext(imm6) replicates bit 5 into bits [7:6].
  - zext(imm6) places zeros in bits [7:6].
- FS codes: 0 pass A, 1 A+B, 2 A−B, 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 pass B, 8 A<<1. Codes 9–15 are never driven.
- Opcodes. Unless noted: DA=DR, AA=SA, BA=SB, MB=0, CS=0, RW=1.
  - 0 NOP: RW=0.
  - 1 MOV: FS=0.
  - 2 ADD: FS=1.
  - 3 SUB: FS=2.
  - 4 AND: FS=3.
  - 5 OR: FS=4.
  - 6 XOR: FS=5.
  - 7 NOT: FS=6.
  - 8 ADI: MB=1, CS=sext, FS=1.
  - 9 ANI: MB=1, CS=zext, FS=3.
  - A ORI: MB=1, CS=zext, FS=4.
  - B LDI: MB=1, CS=zext, FS=7.
  - C BRZ: AA=SA, FS=0, RW=0. If zero==1, PC ← PC+sext(imm6).
  - D JMP: RW=0, PC ← PC+sext(imm6).
  - E SHL: FS=8.
  - F HLT: RW=0, go to HALT.
- States:
  - IDLE: start=1 → FETCH.
  - FETCH: on instr_valid=1, IR ← instr_in, → EXEC. Otherwise stay and hold pc_out.
  - EXEC: control word decoded from IR for exactly one cycle. At the EXEC clock edge PC is updated (branch target, or PC+1) and state → FETCH. HLT → HALT with PC unchanged.
  - HALT: terminal; only rst exits.
- Control word is combinational from state and IR. Outside EXEC: DA=AA=BA=0, MB=0, CS=0, FS=0, RW=0.
- PC arithmetic is mod 256.
  - 0xFF+1 = 0x00.
  - Branch target wraps in both directions, e.g. 0x02+(−4) = 0xFE.
- BRZ/JMP offset is relative to the branch's own address, so offset 0 loops on itself.
- start is ignored outside IDLE. instr_valid is ignored outside FETCH.
- zero is sampled only in EXEC of BRZ.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, PC=0x00, IR=0x0000.
  - All outputs 0: fetch_req, busy, halted, RW, MB, CS, FS, DA, AA, BA.
- Assertion of rst during EXEC drops RW in the same cycle; no write is issued.
- start high at edge n → FETCH from cycle n+1; fetch_req=1 in cycle n+1.
- With instr_valid high on the first FETCH cycle, each instruction takes 2 cycles: FETCH then EXEC. Each wait cycle in FETCH adds 1.
- The new pc_out is visible in the FETCH cycle after EXEC.
- halted rises the cycle after HLT's EXEC. busy=0 from then on.

## Test plan
- Reset/start: release rst with start=1 for one cycle.
  - All outputs are 0 before start.
  - fetch_req=1 and pc_out=0x00 on the next cycle.
- ALU register op: ADD R3←R1+R2 (0x2650), valid immediately.
  - EXEC cycle shows DA=3, AA=1, BA=2, MB=0, FS=1, RW=1.
  - pc_out=0x01 on the next FETCH.
- Immediate extension:
  - ADI R1←R1+(−1) (0x827F) → MB=1, CS=0xFF, FS=1.
  - ANI with imm6=0x3F → CS=0x3F.
  - LDI R5 imm6=0x2A (0xBA2A) → CS=0x2A, FS=7.
- Branches:
  - At PC=0x02, BRZ imm6=−4 (0xC03C) with zero=1 → pc_out=0xFE.
  - Same instruction with zero=0 → pc_out=0x03.
  - JMP at PC=0xFF with offset +1 → pc_out=0x00.
- Fetch stall: hold instr_valid=0 for 3 cycles in FETCH.
  - fetch_req stays 1, pc_out is stable, RW stays 0.
  - EXEC occurs the cycle after valid.
- HLT and reset mid-EXEC:
  - HLT → halted=1, busy=0; start and instr_valid are ignored thereafter.
  - rst asserted during an ADD EXEC → RW=0 in the same cycle, pc_out=0x00.

Source files
------------

// File: rtl/mcu_control_sequencer.sv
// mcu_control_sequencer
// Multi-cycle fetch/execute controller for the 8-bit MCU datapath. Fetches a
// 16-bit instruction through a valid-qualified handshake, decodes it into the
// one-cycle control word (DA, AA, BA, MB, CS, FS, RW), and owns the program
// counter, including conditional and unconditional relative branches.
module mcu_control_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        zero,
  output logic [7:0]  pc_out,
  output logic        fetch_req,
  output logic [2:0]  DA,
  output logic [2:0]  AA,
  output logic [2:0]  BA,
  output logic        MB,
  output logic [7:0]  CS,
  output logic [3:0]  FS,
  output logic        RW,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
    OP_ADI = 4'h8, OP_ANI = 4'h9, OP_ORI = 4'hA, OP_LDI = 4'hB,
    OP_BRZ = 4'hC, OP_JMP = 4'hD, OP_SHL = 4'hE, OP_HLT = 4'hF
  } op_t;

  // Function-unit select codes; 9..15 are never driven.
  localparam logic [3:0] FS_PASS_A = 4'd0;
  localparam logic [3:0] FS_ADD    = 4'd1;
  localparam logic [3:0] FS_SUB    = 4'd2;
  localparam logic [3:0] FS_AND    = 4'd3;
  localparam logic [3:0] FS_OR     = 4'd4;
  localparam logic [3:0] FS_XOR    = 4'd5;
  localparam logic [3:0] FS_NOT_A  = 4'd6;
  localparam logic [3:0] FS_PASS_B = 4'd7;
  localparam logic [3:0] FS_SHL    = 4'd8;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  // Instruction fields
  op_t        op;
  logic [2:0] dr_f, sa_f, sb_f;
  logic [7:0] imm_sext, imm_zext, branch_target;

  assign op            = op_t'(ir_q[15:12]);
  assign dr_f          = ir_q[11:9];
  assign sa_f          = ir_q[8:6];
  assign sb_f          = ir_q[5:3];
  assign imm_sext      = {{2{ir_q[5]}}, ir_q[5:0]};
  assign imm_zext      = {2'b00, ir_q[5:0]};
  // Relative to the branch's own address; 8-bit add wraps mod 256.
  assign branch_target = pc_q + imm_sext;

  // State, program counter and instruction register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC update and instruction capture.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + 8'd1;
        if (op == OP_HLT) begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end else if (op == OP_JMP || (op == OP_BRZ && zero)) begin
          pc_d = branch_target;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control word decode; only live during EXEC, all zero otherwise.
  always_comb begin
    DA = 3'd0;
    AA = 3'd0;
    BA = 3'd0;
    MB = 1'b0;
    CS = 8'h00;
    FS = FS_PASS_A;
    RW = 1'b0;
    if (state_q == ST_EXEC) begin
      DA = dr_f;
      AA = sa_f;
      BA = sb_f;
      RW = 1'b1;
      unique case (op)
        OP_NOP: RW = 1'b0;
        OP_MOV: FS = FS_PASS_A;
        OP_ADD: FS = FS_ADD;
        OP_SUB: FS = FS_SUB;
        OP_AND: FS = FS_AND;
        OP_OR:  FS = FS_OR;
        OP_XOR: FS = FS_XOR;
        OP_NOT: FS = FS_NOT_A;
        OP_ADI: begin MB = 1'b1; CS = imm_sext; FS = FS_ADD;    end
        OP_ANI: begin MB = 1'b1; CS = imm_zext; FS = FS_AND;    end
        OP_ORI: begin MB = 1'b1; CS = imm_zext; FS = FS_OR;     end
        OP_LDI: begin MB = 1'b1; CS = imm_zext; FS = FS_PASS_B; end
        OP_BRZ: begin FS = FS_PASS_A; RW = 1'b0; end
        OP_JMP: RW = 1'b0;
        OP_SHL: FS = FS_SHL;
        OP_HLT: RW = 1'b0;
        default: RW = 1'b0;
      endcase
    end
  end

  assign pc_out    = pc_q;
  assign fetch_req = (state_q == ST_FETCH);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_mcu_control_sequencer.sv
// Directed testbench for mcu_control_sequencer. Inputs change 1 ns after each
// rising edge; outputs are compared at that same point, away from the edge.
module tb_mcu_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        zero;
  logic [7:0]  pc_out;
  logic        fetch_req;
  logic [2:0]  DA, AA, BA;
  logic        MB;
  logic [7:0]  CS;
  logic [3:0]  FS;
  logic        RW;
  logic        busy;
  logic        halted;

  int n_checks = 0;
  int n_fails  = 0;

  mcu_control_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .zero       (zero),
    .pc_out     (pc_out),
    .fetch_req  (fetch_req),
    .DA         (DA),
    .AA         (AA),
    .BA         (BA),
    .MB         (MB),
    .CS         (CS),
    .FS         (FS),
    .RW         (RW),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the full control word in one call.
  task automatic check_cw(input string tag, input logic [2:0] da, input logic [2:0] aa,
                          input logic [2:0] ba, input logic mb, input logic [7:0] cs,
                          input logic [3:0] fs, input logic rw);
    check({tag, ".DA"}, 32'(DA), 32'(da));
    check({tag, ".AA"}, 32'(AA), 32'(aa));
    check({tag, ".BA"}, 32'(BA), 32'(ba));
    check({tag, ".MB"}, 32'(MB), 32'(mb));
    check({tag, ".CS"}, 32'(CS), 32'(cs));
    check({tag, ".FS"}, 32'(FS), 32'(fs));
    check({tag, ".RW"}, 32'(RW), 32'(rw));
  endtask

  // Status outputs: fetch_req, busy, halted, pc_out.
  task automatic check_st(input string tag, input logic fr, input logic by,
                          input logic ht, input logic [7:0] pc);
    check({tag, ".fetch_req"}, 32'(fetch_req), 32'(fr));
    check({tag, ".busy"},      32'(busy),      32'(by));
    check({tag, ".halted"},    32'(halted),    32'(ht));
    check({tag, ".pc_out"},    32'(pc_out),    32'(pc));
  endtask

  // Present one instruction in FETCH with valid immediately; ends in EXEC.
  task automatic fetch(input logic [15:0] instr, input logic z);
    instr_in    = instr;
    instr_valid = 1'b1;
    zero        = z;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; instr_in = 16'h0000; instr_valid = 1'b0; zero = 1'b0;
    step(); step();
    check_st("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    check_cw("reset", 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 4'd0, 1'b0);

    // Release reset with start held one cycle
    rst = 1'b0;
    check_st("idle", 1'b0, 1'b0, 1'b0, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    check_st("first_fetch", 1'b1, 1'b1, 1'b0, 8'h00);
    check_cw("first_fetch", 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 4'd0, 1'b0);

    // ADD R3 <- R1 + R2 at PC 0x00
    fetch(16'h2650, 1'b0);
    check_st("add_exec", 1'b0, 1'b1, 1'b0, 8'h00);
    check_cw("add_exec", 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 4'd1, 1'b1);
    step();
    check_st("add_next", 1'b1, 1'b1, 1'b0, 8'h01);

    // ADI R1 <- R1 + (-1) at PC 0x01
    fetch(16'h827F, 1'b0);
    check_cw("adi_exec", 3'd1, 3'd1, 3'd7, 1'b1, 8'hFF, 4'd1, 1'b1);
    step();
    check("adi_pc", 32'(pc_out), 32'h02);

    // BRZ -4 at PC 0x02, zero=0: falls through
    fetch(16'hC03C, 1'b0);
    check_cw("brz_nt_exec", 3'd0, 3'd0, 3'd7, 1'b0, 8'h00, 4'd0, 1'b0);
    step();
    check("brz_nt_pc", 32'(pc_out), 32'h03);

    // JMP -1 at PC 0x03 back to 0x02
    fetch(16'hD03F, 1'b0);
    check("jmp_back_rw", 32'(RW), 32'd0);
    step();
    check("jmp_back_pc", 32'(pc_out), 32'h02);

    // BRZ -4 at PC 0x02, zero=1: wraps down to 0xFE
    fetch(16'hC03C, 1'b0);
    zero = 1'b1;
    step();
    zero = 1'b0;
    check("brz_t_pc", 32'(pc_out), 32'hFE);

    // ANI R2, imm6=0x3F at PC 0xFE: zero extension
    fetch(16'h943F, 1'b0);
    check_cw("ani_exec", 3'd2, 3'd0, 3'd7, 1'b1, 8'h3F, 4'd3, 1'b1);
    step();
    check("ani_pc", 32'(pc_out), 32'hFF);

    // JMP +1 at PC 0xFF wraps to 0x00
    fetch(16'hD001, 1'b0);
    step();
    check("jmp_wrap_pc", 32'(pc_out), 32'h00);

    // LDI R5, 0x2A at PC 0x00
    fetch(16'hBA2A, 1'b0);
    check_cw("ldi_exec", 3'd5, 3'd0, 3'd5, 1'b1, 8'h2A, 4'd7, 1'b1);
    step();
    check("ldi_pc", 32'(pc_out), 32'h01);

    // Fetch stall: three cycles with instr_valid low at PC 0x01
    instr_in = 16'h3650;
    for (int i = 0; i < 3; i++) begin
      step();
      check_st("stall", 1'b1, 1'b1, 1'b0, 8'h01);
      check("stall.RW", 32'(RW), 32'd0);
    end
    fetch(16'h3650, 1'b0);
    check_cw("sub_exec", 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 4'd2, 1'b1);
    step();
    check("sub_pc", 32'(pc_out), 32'h02);

    // HLT at PC 0x02
    fetch(16'hF000, 1'b0);
    check("hlt_exec_rw", 32'(RW), 32'd0);
    check("hlt_exec_halted", 32'(halted), 32'd0);
    step();
    check_st("halt", 1'b0, 1'b0, 1'b1, 8'h02);
    start = 1'b1; instr_valid = 1'b1; instr_in = 16'h2650;
    step(); step(); step();
    check_st("halt_ignore", 1'b0, 1'b0, 1'b1, 8'h02);
    check("halt_ignore.RW", 32'(RW), 32'd0);
    start = 1'b0; instr_valid = 1'b0;

    // Reset asserted mid-EXEC of an ADD
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_st("rst_from_halt", 1'b0, 1'b0, 1'b0, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(16'h2650, 1'b0);
    check("rst_exec_rw_before", 32'(RW), 32'd1);
    step();
    check("rst_exec_pc_before", 32'(pc_out), 32'h01);
    fetch(16'h2650, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_exec_rw", 32'(RW), 32'd0);
    check("rst_exec_pc", 32'(pc_out), 32'h00);
    check("rst_exec_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
